// File: rtl/ocp_master_arbiter.sv
// Round-robin arbiter that shares one OCP master port (simple RD/WR, no bursts)
// among NREQ local requesters, with per-requester completion pulses.
//
// state  | meaning
// S_IDLE | no transaction; pick the next eligible requester
// S_CMD  | command driven on the bus, waiting for SCmdAccept
// S_RESP | read accepted, waiting for SResp or timeout
module ocp_master_arbiter #(
    parameter int NREQ        = 4,
    parameter int MADDR_WIDTH = 32,
    parameter int MDATA_WIDTH = 32,
    parameter int TIMEOUT     = 256
) (
    input  logic                          Clk,
    input  logic                          reset,
    input  logic                          EnableClk,
    input  logic [NREQ-1:0]               req_read,
    input  logic [NREQ-1:0]               req_write,
    input  logic [NREQ*MADDR_WIDTH-1:0]   req_addr,
    input  logic [NREQ*MDATA_WIDTH-1:0]   req_wdata,
    output logic [NREQ-1:0]               grant,
    output logic [NREQ-1:0]               done,
    output logic [MDATA_WIDTH-1:0]        rdata,
    output logic                          err,
    output logic [2:0]                    MCmd,
    output logic [MADDR_WIDTH-1:0]        MAddr,
    output logic [MDATA_WIDTH-1:0]        MData,
    output logic                          MDataValid,
    input  logic                          SCmdAccept,
    input  logic [1:0]                    SResp,
    input  logic [MDATA_WIDTH-1:0]        SData
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0]    CMD_IDLE  = 3'b000;
    localparam logic [2:0]    CMD_WR    = 3'b001;
    localparam logic [2:0]    CMD_RD    = 3'b010;
    localparam logic [1:0]    RESP_NULL = 2'b00;
    localparam logic [1:0]    RESP_DVA  = 2'b01;
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [PW-1:0] PTR_RST   = PW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE     = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_RESP} state_t;

    state_t                  r_state,      w_state_nxt;
    logic [PW-1:0]           r_ptr,        w_ptr_nxt;
    logic [CW-1:0]           r_cnt,        w_cnt_nxt;
    logic [NREQ-1:0]         r_grant,      w_grant_nxt;
    logic [NREQ-1:0]         r_done,       w_done_nxt;
    logic [MDATA_WIDTH-1:0]  r_rdata,      w_rdata_nxt;
    logic                    r_err,        w_err_nxt;
    logic [2:0]              r_mcmd,       w_mcmd_nxt;
    logic [MADDR_WIDTH-1:0]  r_maddr,      w_maddr_nxt;
    logic [MDATA_WIDTH-1:0]  r_mdata,      w_mdata_nxt;
    logic                    r_mdv,        w_mdv_nxt;

    logic [NREQ-1:0]         w_eligible;
    logic [PW-1:0]           w_win;
    logic [MADDR_WIDTH-1:0]  w_win_addr;
    logic [MDATA_WIDTH-1:0]  w_win_data;

    // Scan from the pointer downwards in distance so the closest index after ptr wins last.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] elig,
                                              input logic [PW-1:0]   ptr);
        logic [PW-1:0] pick;
        int            idx;
        pick = ptr;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (elig[idx]) pick = PW'(idx);
        end
        return pick;
    endfunction

    // A requester that just saw its done still holds its request for a cycle; mask it.
    always_comb begin
        w_eligible = (req_read | req_write) & ~r_done;
        w_win      = rr_pick(w_eligible, r_ptr);
    end

    assign w_win_addr = req_addr[int'(w_win) * MADDR_WIDTH +: MADDR_WIDTH];
    assign w_win_data = req_wdata[int'(w_win) * MDATA_WIDTH +: MDATA_WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        w_mcmd_nxt  = r_mcmd;
        w_maddr_nxt = r_maddr;
        w_mdata_nxt = r_mdata;
        w_mdv_nxt   = r_mdv;

        case (r_state)
            S_IDLE: begin
                if (|w_eligible) begin
                    w_ptr_nxt   = w_win;
                    w_grant_nxt = ONE << w_win;
                    w_maddr_nxt = w_win_addr;
                    w_mdata_nxt = w_win_data;
                    if (req_read[w_win]) begin
                        w_mcmd_nxt = CMD_RD;
                        w_mdv_nxt  = 1'b0;
                    end else begin
                        w_mcmd_nxt = CMD_WR;
                        w_mdv_nxt  = 1'b1;
                    end
                    w_state_nxt = S_CMD;
                end
            end

            S_CMD: begin
                if (SCmdAccept) begin
                    w_mcmd_nxt = CMD_IDLE;
                    w_mdv_nxt  = 1'b0;
                    if (r_mcmd == CMD_WR) begin
                        w_done_nxt  = r_grant;
                        w_err_nxt   = 1'b0;
                        w_grant_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_RESP;
                    end
                end
            end

            S_RESP: begin
                if (SResp != RESP_NULL) begin
                    w_rdata_nxt = SData;
                    w_err_nxt   = (SResp != RESP_DVA);
                    w_done_nxt  = r_grant;
                    w_grant_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_rdata_nxt = '0;
                    w_err_nxt   = 1'b1;
                    w_done_nxt  = r_grant;
                    w_grant_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= PTR_RST;
            r_cnt   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_mcmd  <= CMD_IDLE;
            r_maddr <= '0;
            r_mdata <= '0;
            r_mdv   <= 1'b0;
        end else if (EnableClk) begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
            r_mcmd  <= w_mcmd_nxt;
            r_maddr <= w_maddr_nxt;
            r_mdata <= w_mdata_nxt;
            r_mdv   <= w_mdv_nxt;
        end
    end

    assign grant      = r_grant;
    assign done       = r_done;
    assign rdata      = r_rdata;
    assign err        = r_err;
    assign MCmd       = r_mcmd;
    assign MAddr      = r_maddr;
    assign MData      = r_mdata;
    assign MDataValid = r_mdv;

endmodule

// File: tb/tb_ocp_master_arbiter.sv
// Scoreboard bench for ocp_master_arbiter: expected commands and completions are
// queued by the stimulus and popped by independent bus/done monitors.
module tb_ocp_master_arbiter;

    logic         Clk = 1'b0;
    logic         reset;
    logic         EnableClk;
    logic [3:0]   req_read, req_write;
    logic [127:0] req_addr, req_wdata;
    logic [3:0]   grant, done;
    logic [31:0]  rdata;
    logic         err;
    logic [2:0]   MCmd;
    logic [31:0]  MAddr, MData;
    logic         MDataValid;
    logic         SCmdAccept;
    logic [1:0]   SResp;
    logic [31:0]  SData;

    ocp_master_arbiter #(
        .NREQ(4), .MADDR_WIDTH(32), .MDATA_WIDTH(32), .TIMEOUT(8)
    ) dut (
        .Clk(Clk), .reset(reset), .EnableClk(EnableClk),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .grant(grant), .done(done), .rdata(rdata), .err(err),
        .MCmd(MCmd), .MAddr(MAddr), .MData(MData), .MDataValid(MDataValid),
        .SCmdAccept(SCmdAccept), .SResp(SResp), .SData(SData)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic        mdv;
        logic [3:0]  grant;
    } cmd_t;

    typedef struct {
        logic [3:0]  done;
        logic [31:0] rdata;
        logic        chk_rdata;
        logic        err;
    } cpl_t;

    cmd_t cmd_q[$];
    cpl_t cpl_q[$];
    cmd_t mon_c;
    cpl_t mon_d;
    int   checks = 0;
    int   errors = 0;
    logic [2:0] prev_mcmd = 3'b000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_done(input int idx, input string name);
        int n;
        n = 0;
        while (done[idx] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (done[idx] !== 1'b1) begin
            errors++;
            $display("FAIL %s: no done[%0d] after %0d cycles, required within 40", name, idx, n);
        end
    endtask

    // Bus monitor: each new command on the bus is compared with the next expected one.
    always @(negedge Clk) begin
        if (MCmd != 3'b000 && prev_mcmd == 3'b000) begin
            if (cmd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmd_unexpected: MCmd %0b grant %0b with nothing expected", MCmd, grant);
            end else begin
                mon_c = cmd_q.pop_front();
                check("cmd_MCmd", 64'(MCmd), 64'(mon_c.cmd));
                check("cmd_MAddr", 64'(MAddr), 64'(mon_c.addr));
                check("cmd_MData", 64'(MData), 64'(mon_c.data));
                check("cmd_MDataValid", 64'(MDataValid), 64'(mon_c.mdv));
                check("cmd_grant", 64'(grant), 64'(mon_c.grant));
            end
        end
        prev_mcmd <= MCmd;
    end

    // Completion monitor.
    always @(negedge Clk) begin
        if (done != 4'b0000) begin
            if (cpl_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: done %0b with nothing expected", done);
            end else begin
                mon_d = cpl_q.pop_front();
                check("cpl_done", 64'(done), 64'(mon_d.done));
                check("cpl_err", 64'(err), 64'(mon_d.err));
                check("cpl_grant_clear", 64'(grant), 64'(4'b0000));
                if (mon_d.chk_rdata) check("cpl_rdata", 64'(rdata), 64'(mon_d.rdata));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int n_done;
        logic [1:0]  resp_list [2];
        logic [31:0] sdata_list [2];
        int          order [5];

        reset = 1'b1; EnableClk = 1'b1;
        req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        SCmdAccept = 1'b0; SResp = 2'b00; SData = '0;
        repeat (3) step();

        check("rst_grant", 64'(grant), 64'(4'b0000));
        check("rst_done", 64'(done), 64'(4'b0000));
        check("rst_MCmd", 64'(MCmd), 64'(3'b000));
        check("rst_MDataValid", 64'(MDataValid), 64'(1'b0));
        check("rst_rdata_err", 64'({rdata, err}), 64'(33'h0));
        reset = 1'b0;

        // 1: write from requester 0, accepted on the 3rd command cycle
        req_addr[0 +: 32] = 32'h10; req_wdata[0 +: 32] = 32'hA5; req_write[0] = 1'b1;
        cmd_q.push_back('{3'b001, 32'h10, 32'hA5, 1'b1, 4'b0001});
        cpl_q.push_back('{4'b0001, 32'h0, 1'b1, 1'b0});
        for (int c = 0; c < 3; c++) begin
            step();
            check("t1_hold_MCmd", 64'(MCmd), 64'(3'b001));
            check("t1_hold_MAddr", 64'(MAddr), 64'(32'h10));
            check("t1_hold_MDataValid", 64'(MDataValid), 64'(1'b1));
            if (c == 2) SCmdAccept = 1'b1;
        end
        step();
        check("t1_after_accept_MCmd", 64'(MCmd), 64'(3'b000));
        check("t1_done", 64'(done), 64'(4'b0001));
        req_write[0] = 1'b0; SCmdAccept = 1'b0;
        step();
        check("t1_done_one_cycle", 64'(done), 64'(4'b0000));

        // 2: read from requester 2 with DVA
        req_addr[64 +: 32] = 32'h40; req_read[2] = 1'b1; SCmdAccept = 1'b1;
        cmd_q.push_back('{3'b010, 32'h40, 32'h0, 1'b0, 4'b0100});
        cpl_q.push_back('{4'b0100, 32'hDEADBEEF, 1'b1, 1'b0});
        step();
        check("t2_rd_cmd", 64'(MCmd), 64'(3'b010));
        step();
        check("t2_rd_one_cycle", 64'(MCmd), 64'(3'b000));
        SCmdAccept = 1'b0;
        step();
        SResp = 2'b01; SData = 32'hDEADBEEF;
        wait_done(2, "t2_wait_done");
        req_read[2] = 1'b0; SResp = 2'b00; SData = '0;
        step();

        // 3: round-robin with all four writers held, accept tied high
        reset = 1'b1;
        step();
        reset = 1'b0;
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin
            req_addr[i*32 +: 32]  = 32'h100 + 32'(i * 16);
            req_wdata[i*32 +: 32] = 32'h1000 + 32'(i);
        end
        for (int j = 0; j < 5; j++) begin
            cmd_q.push_back('{3'b001, 32'h100 + 32'(order[j] * 16), 32'h1000 + 32'(order[j]),
                              1'b1, 4'(1 << order[j])});
            cpl_q.push_back('{4'(1 << order[j]), 32'h0, 1'b0, 1'b0});
        end
        req_write = 4'b1111; SCmdAccept = 1'b1;
        n_done = 0;
        for (int c = 0; c < 40 && n_done < 5; c++) begin
            step();
            if (done != 4'b0000) n_done++;
        end
        req_write = '0; SCmdAccept = 1'b0;
        check("t3_done_count", 64'(n_done), 64'(5));
        step();
        step();

        // 4A: error responses (ERR, then FAIL) for requester 1
        resp_list  = '{2'b11, 2'b10};
        sdata_list = '{32'h1234, 32'h5678};
        req_addr[32 +: 32] = 32'h80; req_wdata[32 +: 32] = 32'h0;
        for (int r = 0; r < 2; r++) begin
            cmd_q.push_back('{3'b010, 32'h80, 32'h0, 1'b0, 4'b0010});
            cpl_q.push_back('{4'b0010, sdata_list[r], 1'b1, 1'b1});
            req_read[1] = 1'b1; SCmdAccept = 1'b1;
            step();
            step();
            SCmdAccept = 1'b0; SResp = resp_list[r]; SData = sdata_list[r];
            wait_done(1, "t4a_wait_done");
            req_read[1] = 1'b0; SResp = 2'b00;
            step();
        end

        // 4B: no response -> forced error after TIMEOUT=8 RESP cycles
        req_addr[96 +: 32] = 32'hC0; req_wdata[96 +: 32] = 32'h0; SData = 32'hFFFFFFFF;
        cmd_q.push_back('{3'b010, 32'hC0, 32'h0, 1'b0, 4'b1000});
        cpl_q.push_back('{4'b1000, 32'h0, 1'b1, 1'b1});
        req_read[3] = 1'b1; SCmdAccept = 1'b1;
        step();
        step();
        SCmdAccept = 1'b0;
        n = 0;
        while (done[3] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("t4b_timeout_cycles", 64'(n), 64'(8));
        req_read[3] = 1'b0; SData = '0;
        step();

        // 5A: stall in CMD with accept offered; request address changed meanwhile
        req_addr[32 +: 32] = 32'h55; req_wdata[32 +: 32] = 32'h66; req_write[1] = 1'b1;
        cmd_q.push_back('{3'b001, 32'h55, 32'h66, 1'b1, 4'b0010});
        cpl_q.push_back('{4'b0010, 32'h0, 1'b0, 1'b0});
        step();
        EnableClk = 1'b0; SCmdAccept = 1'b1; req_addr[32 +: 32] = 32'h99;
        for (int c = 0; c < 5; c++) begin
            step();
            check("t5_stall_MCmd", 64'(MCmd), 64'(3'b001));
            check("t5_stall_grant_done", 64'({grant, done}), 64'({4'b0010, 4'b0000}));
            check("t5_stall_MAddr", 64'(MAddr), 64'(32'h55));
        end
        EnableClk = 1'b1;
        step();
        check("t5_accept_after_stall", 64'(done), 64'(4'b0010));
        req_write[1] = 1'b0; SCmdAccept = 1'b0;
        step();

        // 5B: reset in the middle of a read response
        req_addr[64 +: 32] = 32'h200; req_wdata[64 +: 32] = 32'h0; req_read[2] = 1'b1;
        SCmdAccept = 1'b1;
        cmd_q.push_back('{3'b010, 32'h200, 32'h0, 1'b0, 4'b0100});
        step();
        step();
        SCmdAccept = 1'b0;
        step();
        step();
        req_addr[0 +: 32] = 32'h300; req_wdata[0 +: 32] = 32'h77; req_write[0] = 1'b1;
        reset = 1'b1;
        step();
        check("t5_rst_MCmd", 64'(MCmd), 64'(3'b000));
        check("t5_rst_grant_done", 64'({grant, done}), 64'(8'h00));
        reset = 1'b0; SCmdAccept = 1'b1;
        cmd_q.push_back('{3'b001, 32'h300, 32'h77, 1'b1, 4'b0001});
        cpl_q.push_back('{4'b0001, 32'h0, 1'b0, 1'b0});
        step();
        check("t5_rst_winner", 64'(grant), 64'(4'b0001));
        wait_done(0, "t5_wait_done");
        req_write = '0; req_read = '0; SCmdAccept = 1'b0;
        step();
        step();

        check("queues_empty", 64'(cmd_q.size() + cpl_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
